// File: rtl/fpu_dispatch_if.sv
// fpu_dispatch_if: op/operand/result handshakes and the external-unit request/response channels; slave = dispatcher view, master = environment view
interface fpu_dispatch_if #(parameter int W = 32) ();
  logic [3:0] op;
  logic [W-1:0] in1, in2, out, ext_a, ext_b, ext_z;
  logic in_stb, in_ack, out_stb, out_ack, exc_invalid, exc_timeout;
  logic [2:0] ext_op;
  logic ext_stb, ext_ack, ext_z_stb, ext_z_ack;
  modport slave (
    input op, in1, in2, in_stb, out_ack, ext_ack, ext_z, ext_z_stb,
    output in_ack, out, out_stb, exc_invalid, exc_timeout, ext_a, ext_b, ext_op, ext_stb, ext_z_ack
  );
  modport master (
    output op, in1, in2, in_stb, out_ack, ext_ack, ext_z, ext_z_stb,
    input in_ack, out, out_stb, exc_invalid, exc_timeout, ext_a, ext_b, ext_op, ext_stb, ext_z_ack
  );
endinterface

// File: rtl/fpu_dispatch.sv
// fpu_dispatch: runs sign-inject/compare/min-max ops locally and forwards arithmetic/convert ops to an external unit; ports clk, rst, bus (fpu_dispatch_if.slave); FPU_DISPATCH_TIMEOUT_EN enables the external-wait watchdog
module fpu_dispatch #(
  parameter int EXP_W = 8,
  parameter int FRAC_W = 23,
  parameter int TIMEOUT = 1024
) (
  input logic clk,
  input logic rst,
  fpu_dispatch_if.slave bus
);
  localparam int W = 1 + EXP_W + FRAC_W;
  localparam logic [W-1:0] QNAN = {1'b0, {EXP_W{1'b1}}, 1'b1, {(FRAC_W-1){1'b0}}};
  typedef enum logic [1:0] {IDLE, EXT_REQ, EXT_WAIT, DONE} state_t;
  state_t state, state_n;
  logic [3:0] op_q;
  logic [W-1:0] a_q, b_q, res, int_res;
  logic inv, tmo, int_inv, xfer, is_ext, tmo_hit;
  logic sa, sb, nan_a, nan_b, snan_a, snan_b, any_nan, any_snan, zero, lt_t, eq, lt;
  logic [W-2:0] ma, mb;
  assign xfer = bus.in_stb & (state == IDLE);
  assign is_ext = bus.op < 4'd6;
`ifdef FPU_DISPATCH_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1);
  logic [CW-1:0] cnt;
  assign tmo_hit = (state == EXT_REQ || state == EXT_WAIT) && cnt == CW'(TIMEOUT - 1);
  always_ff @(posedge clk)
    if (rst || xfer) cnt <= '0;
    else if (state == EXT_REQ || state == EXT_WAIT) cnt <= cnt + 1'b1;
`else
  assign tmo_hit = 1'b0;
`endif
  assign sa = bus.in1[W-1];
  assign sb = bus.in2[W-1];
  assign ma = bus.in1[W-2:0];
  assign mb = bus.in2[W-2:0];
  assign nan_a = &bus.in1[W-2:FRAC_W] & |bus.in1[FRAC_W-1:0];
  assign nan_b = &bus.in2[W-2:FRAC_W] & |bus.in2[FRAC_W-1:0];
  assign snan_a = nan_a & ~bus.in1[FRAC_W-1];
  assign snan_b = nan_b & ~bus.in2[FRAC_W-1];
  assign any_nan = nan_a | nan_b;
  assign any_snan = snan_a | snan_b;
  assign zero = ~|ma & ~|mb;
  // total order with -0 below +0; compares mask the zero case, min/max keep it
  assign lt_t = (sa != sb) ? sa : (sa ? ma > mb : ma < mb);
  assign eq = (bus.in1 == bus.in2) | zero;
  assign lt = lt_t & ~zero;
  always_comb begin
    int_res = '0;
    int_inv = 1'b0;
    case (bus.op)
      4'd6: int_res = {sb, bus.in1[W-2:0]};
      4'd7: int_res = {~sb, bus.in1[W-2:0]};
      4'd11: int_res = {sa ^ sb, bus.in1[W-2:0]};
      4'd8: begin
        int_res = W'(eq & ~any_nan);
        int_inv = any_snan;
      end
      4'd9: begin
        int_res = W'(lt & ~any_nan);
        int_inv = any_nan;
      end
      4'd10: begin
        int_res = W'((lt | eq) & ~any_nan);
        int_inv = any_nan;
      end
      4'd12, 4'd13: begin
        int_res = (nan_a & nan_b) ? QNAN : nan_a ? bus.in2 : nan_b ? bus.in1 :
                  (lt_t ^ bus.op[0]) ? bus.in1 : bus.in2;
        int_inv = any_snan;
      end
      4'd14, 4'd15: int_inv = 1'b1;
      default: ;
    endcase
  end
  always_ff @(posedge clk)
    if (rst) begin
      state <= IDLE;
      res <= '0;
      inv <= 1'b0;
      tmo <= 1'b0;
    end else begin
      state <= state_n;
      if (xfer) begin
        op_q <= bus.op;
        a_q <= bus.in1;
        b_q <= bus.in2;
      end
      if (xfer && !is_ext) begin
        res <= int_res;
        inv <= int_inv;
        tmo <= 1'b0;
      end else if (state == EXT_WAIT && bus.ext_z_stb) begin
        res <= bus.ext_z;
        inv <= 1'b0;
        tmo <= 1'b0;
      end else if (tmo_hit) begin
        res <= QNAN;
        inv <= 1'b0;
        tmo <= 1'b1;
      end
    end
  always_comb begin
    state_n = state;
    case (state)
      IDLE: state_n = xfer ? (is_ext ? EXT_REQ : DONE) : IDLE;
      EXT_REQ: state_n = tmo_hit ? DONE : bus.ext_ack ? EXT_WAIT : EXT_REQ;
      EXT_WAIT: state_n = (bus.ext_z_stb || tmo_hit) ? DONE : EXT_WAIT;
      DONE: state_n = bus.out_ack ? IDLE : DONE;
    endcase
  end
  always_comb begin
    bus.in_ack = state == IDLE;
    bus.out_stb = state == DONE;
    bus.ext_stb = state == EXT_REQ;
    bus.ext_z_ack = (state == EXT_WAIT) & bus.ext_z_stb;
    bus.out = res;
    bus.exc_invalid = inv;
    bus.exc_timeout = tmo;
    bus.ext_a = a_q;
    // the external unit has no subtract, so fsub becomes fadd with in2 negated
    bus.ext_b = (op_q == 4'd1) ? {~b_q[W-1], b_q[W-2:0]} : b_q;
    bus.ext_op = (op_q == 4'd1) ? 3'd0 : op_q[2:0];
  end
endmodule

// File: tb/tb_fpu_dispatch.sv
// tb_fpu_dispatch: randomized and directed checks of fpu_dispatch against a value-level reference model
module tb_fpu_dispatch;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int n_tests = 0;
  int n_fail = 0;
  fpu_dispatch_if #(.W(32)) bus ();
  fpu_dispatch #(.EXP_W(8), .FRAC_W(23), .TIMEOUT(16)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  function automatic bit is_nan(input logic [31:0] x);
    return x[30:23] == 8'hFF && x[22:0] != 0;
  endfunction
  function automatic longint key(input logic [31:0] x);
    return x[31] ? -longint'(x[30:0]) : longint'(x[30:0]);
  endfunction
  function automatic void model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] r, output logic inv);
    bit na, nb, sna, snb, aless;
    longint ka, kb;
    na = is_nan(a);
    nb = is_nan(b);
    sna = na && !a[22];
    snb = nb && !b[22];
    ka = key(a);
    kb = key(b);
    r = 0;
    inv = 0;
    case (op)
      4'd6: r = {b[31], a[30:0]};
      4'd7: r = {~b[31], a[30:0]};
      4'd11: r = {a[31] ^ b[31], a[30:0]};
      4'd8: begin r = 32'(!na && !nb && ka == kb); inv = sna || snb; end
      4'd9: begin r = 32'(!na && !nb && ka < kb); inv = na || nb; end
      4'd10: begin r = 32'(!na && !nb && ka <= kb); inv = na || nb; end
      4'd12, 4'd13: begin
        inv = sna || snb;
        if (na && nb) r = 32'h7FC00000;
        else if (na) r = b;
        else if (nb) r = a;
        else begin
          aless = ka < kb || (ka == kb && a[31] && !b[31]);
          r = ((op == 4'd12) == aless) ? a : b;
        end
      end
      4'd14, 4'd15: inv = 1;
      default: ;
    endcase
  endfunction
  function automatic logic [31:0] pick();
    logic [31:0] sp [8] = '{32'h0, 32'h80000000, 32'h7F800000, 32'hFF800000,
                            32'h7FC00000, 32'h7F800001, 32'h3F800000, 32'hBF800000};
    return ($urandom_range(0, 2) == 0) ? sp[$urandom_range(0, 7)] : $urandom;
  endfunction
  task automatic xact(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b, input logic [31:0] z);
    logic [31:0] er;
    logic ei;
    model(op, a, b, er, ei);
    @(negedge clk);
    check("in_ack_idle", 32'(bus.in_ack), 1);
    bus.op = op;
    bus.in1 = a;
    bus.in2 = b;
    bus.in_stb = 1;
    @(negedge clk);
    bus.in_stb = 0;
    if (op < 4'd6) begin
      check("ext_stb", 32'(bus.ext_stb), 1);
      check("ext_a", bus.ext_a, a);
      check("ext_b", bus.ext_b, op == 4'd1 ? b ^ 32'h80000000 : b);
      check("ext_op", 32'(bus.ext_op), op == 4'd1 ? 0 : 32'(op[2:0]));
      repeat ($urandom_range(0, 2)) @(negedge clk);
      check("ext_stb_hold", 32'(bus.ext_stb), 1);
      bus.ext_ack = 1;
      @(negedge clk);
      bus.ext_ack = 0;
      check("ext_stb_drop", 32'(bus.ext_stb), 0);
      repeat ($urandom_range(0, 3)) @(negedge clk);
      check("out_stb_wait", 32'(bus.out_stb), 0);
      bus.ext_z = z;
      bus.ext_z_stb = 1;
      #1;
      check("ext_z_ack", 32'(bus.ext_z_ack), 1);
      @(negedge clk);
      bus.ext_z_stb = 0;
      er = z;
      ei = 0;
    end else check("ext_stb_int", 32'(bus.ext_stb), 0);
    check("out_stb", 32'(bus.out_stb), 1);
    check("out", bus.out, er);
    check("exc_invalid", 32'(bus.exc_invalid), 32'(ei));
    check("exc_timeout", 32'(bus.exc_timeout), 0);
    repeat ($urandom_range(0, 2)) begin
      @(negedge clk);
      check("out_stb_held", 32'(bus.out_stb), 1);
      check("out_held", bus.out, er);
      check("in_ack_done", 32'(bus.in_ack), 0);
    end
    bus.out_ack = 1;
    @(negedge clk);
    bus.out_ack = 0;
    check("out_stb_clr", 32'(bus.out_stb), 0);
  endtask
  initial begin
    bus.op = 0; bus.in1 = 0; bus.in2 = 0; bus.in_stb = 0; bus.out_ack = 0;
    bus.ext_ack = 0; bus.ext_z = 0; bus.ext_z_stb = 0;
    repeat (3) @(negedge clk);
    rst = 0;
    @(negedge clk);
    check("rst_in_ack", 32'(bus.in_ack), 1);
    check("rst_out_stb", 32'(bus.out_stb), 0);
    check("rst_out", bus.out, 0);
    check("rst_ext_stb", 32'(bus.ext_stb), 0);
    check("rst_ext_z_ack", 32'(bus.ext_z_ack), 0);
    check("rst_inv", 32'(bus.exc_invalid), 0);
    check("rst_tmo", 32'(bus.exc_timeout), 0);
    xact(4'd0, 32'h3F800000, 32'h40000000, 32'h40400000);
    xact(4'd1, 32'h40000000, 32'h3F800000, 32'h3F800000);
    xact(4'd9, 32'hFF800000, 32'h00000000, 0);
    xact(4'd9, 32'h7FC00000, 32'h3F800000, 0);
    xact(4'd8, 32'h00000000, 32'h80000000, 0);
    xact(4'd12, 32'h7F800001, 32'h3F800000, 0);
    xact(4'd12, 32'h7F800001, 32'h7FC00000, 0);
    xact(4'd12, 32'h80000000, 32'h00000000, 0);
    xact(4'd13, 32'h80000000, 32'h00000000, 0);
    xact(4'd14, 32'h3F800000, 32'h3F800000, 0);
    xact(4'd6, 32'h3F800000, 32'h80000000, 0);
    for (int i = 0; i < 200; i++) begin
      logic [31:0] a;
      a = pick();
      xact(4'($urandom_range(0, 15)), a, ($urandom_range(0, 4) == 0) ? a : pick(), $urandom);
    end
`ifdef FPU_DISPATCH_TIMEOUT_EN
    begin
      int k;
      @(negedge clk);
      bus.op = 4'd2; bus.in1 = 32'h3F800000; bus.in2 = 32'h3F800000; bus.in_stb = 1;
      @(negedge clk);
      bus.in_stb = 0;
      bus.ext_ack = 1;
      k = 0;
      while (!bus.out_stb && k < 40) begin
        @(negedge clk);
        bus.ext_ack = 0;
        k++;
      end
      check("tmo_cycles", 32'(k), 16);
      check("tmo_out", bus.out, 32'h7FC00000);
      check("tmo_flag", 32'(bus.exc_timeout), 1);
      check("tmo_inv", 32'(bus.exc_invalid), 0);
      check("tmo_ext_stb", 32'(bus.ext_stb), 0);
      check("tmo_ext_z_ack", 32'(bus.ext_z_ack), 0);
      bus.out_ack = 1;
      @(negedge clk);
      bus.out_ack = 0;
    end
`endif
    @(negedge clk);
    bus.op = 4'd0; bus.in1 = 32'h3F800000; bus.in2 = 32'h3F800000; bus.in_stb = 1;
    @(negedge clk);
    bus.in_stb = 0;
    bus.ext_ack = 1;
    @(negedge clk);
    bus.ext_ack = 0;
    check("mid_ext_stb", 32'(bus.ext_stb), 0);
    rst = 1;
    @(negedge clk);
    check("mid_rst_out_stb", 32'(bus.out_stb), 0);
    check("mid_rst_ext_stb", 32'(bus.ext_stb), 0);
    check("mid_rst_out", bus.out, 0);
    rst = 0;
    @(negedge clk);
    check("mid_rel_in_ack", 32'(bus.in_ack), 1);
    check("mid_rel_out_stb", 32'(bus.out_stb), 0);
    repeat (3) @(negedge clk);
    check("mid_no_out_stb", 32'(bus.out_stb), 0);
    xact(4'd10, 32'hBF800000, 32'hBF800000, 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/fpu_dispatch.md
FPU_DISPATCH -- requirements
Module: fpu_dispatch

Interface
REQ-001 Parameter EXP_W, default 8, exponent width.
REQ-002 Parameter FRAC_W, default 23, fraction width; W = 1+EXP_W+FRAC_W.
REQ-003 Parameter TIMEOUT, default 1024, max cycles an external operation may take.
REQ-004 clk  in  1  sole clock; all state changes on rising edge.
REQ-005 rst  in  1  reset, synchronous, active-high.
REQ-006 op  in  4  operation code, sampled on input transfer.
REQ-007 in1, in2  in  W  operands, sampled on input transfer.
REQ-008 in_stb  in  1, in_ack  out  1  input handshake; transfer when both high on a clock edge.
REQ-009 out  out  W, out_stb  out  1, out_ack  in  1  result handshake.
REQ-010 exc_invalid  out  1, exc_timeout  out  1  flags qualified by out_stb.
REQ-011 ext_a, ext_b  out  W, ext_op  out  3, ext_stb  out  1, ext_ack  in  1  external-unit request.
REQ-012 ext_z  in  W, ext_z_stb  in  1, ext_z_ack  out  1  external-unit response.

Function
REQ-013 Op codes: 0000 fadd, 0001 fsub, 0010 fmul, 0011 fdiv, 0100 cvt.s.w, 0101 cvt.w.s (external); 0110 fsgnj, 0111 fsgnjn, 1000 feq, 1001 flt, 1010 fle, 1011 fsgnjx, 1100 fmin, 1101 fmax (internal); 1110/1111 reserved.
REQ-014 FSM states IDLE, EXT_REQ, EXT_WAIT, DONE; in_ack = (state==IDLE), combinational.
REQ-015 IDLE + transfer: latch op/in1/in2; internal or reserved op -> result registered, DONE next cycle (out_stb high one cycle after transfer); external op -> EXT_REQ.
REQ-016 EXT_REQ: ext_stb=1, ext_a=in1, ext_b=in2 (fsub: in2 sign inverted), ext_op=op[2:0] with fsub mapped to 000; on ext_ack -> EXT_WAIT, ext_stb low next cycle.
REQ-017 EXT_WAIT: ext_z_ack = ext_z_stb; on ext_z_stb latch ext_z -> DONE.
REQ-018 DONE: out_stb=1, out/flags stable; on out_ack -> IDLE; in_ack stays 0 until IDLE (no back-to-back bypass).
REQ-019 fsgnj/fsgnjn/fsgnjx: sign = in2.s / ~in2.s / in1.s^in2.s, exponent+fraction from in1; no flags.
REQ-020 Compares return 1 or 0 zero-extended to W; +0 and -0 equal; signed-magnitude ordering.
REQ-021 NaN = exponent all ones, fraction non-zero; sNaN = NaN with fraction MSB 0.
REQ-022 feq with any NaN -> 0; exc_invalid=1 only if either operand sNaN.
REQ-023 flt/fle with any NaN -> 0, exc_invalid=1.
REQ-024 fmin/fmax: -0 < +0; one NaN -> other operand; both NaN -> canonical NaN (sign 0, exp all ones, fraction MSB only); exc_invalid=1 if either sNaN.
REQ-025 Reserved op -> out=0, exc_invalid=1, no external request.
REQ-026 External results: exc_invalid=0, exc_timeout=0 unless REQ-031.

Reset
REQ-027 rst high at edge: state IDLE, out=0, out_stb=0, ext_stb=0, ext_z_ack=0, flags 0, timeout counter 0.
REQ-028 rst mid-operation abandons it; no out_stb for that operation; external unit shares rst.
REQ-029 in_ack=1 in the first cycle after rst deasserts.

Configuration
REQ-030 Macro FPU_DISPATCH_TIMEOUT_EN selects the watchdog.
REQ-031 Defined: counter clears on entering EXT_REQ, increments in EXT_REQ/EXT_WAIT; at TIMEOUT cycles -> DONE with out=canonical NaN, exc_timeout=1, ext_stb/ext_z_ack low.
REQ-032 Undefined: no counter; external wait unbounded; exc_timeout tied 0.

Verification
REQ-033 fadd 0x3F800000+0x40000000, ext unit acks 1 cycle, ext_z=0x40400000 after 3 -> out=0x40400000, out_stb held until out_ack.
REQ-034 fsub in2=0x3F800000 -> ext_b=0xBF800000, ext_op=000.
REQ-035 flt 0xFF800000 < 0x00000000 -> out=1, one cycle latency; flt with 0x7FC00000 -> out=0, exc_invalid=1; feq +0/-0 -> out=1.
REQ-036 fmin 0x7F800001 vs 0x3F800000 -> out=0x3F800000, exc_invalid=1; fmin both NaN -> 0x7FC00000.
REQ-037 Macro defined, TIMEOUT=16, ext_z_stb never asserted -> out=0x7FC00000, exc_timeout=1 after 16 cycles.
REQ-038 rst asserted in EXT_WAIT -> next cycle IDLE, out_stb=0, in_ack=1 after release.
